led_pattern_ctrl: RTL
=====================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 32'd500_000, setting the base step period in clk cycles (legal range 2..2^29).
REQ-002 The block SHALL have parameter DEB_MAX, default 32'd1_000_000, setting the number of stable cycles required to accept a key level.
REQ-003 Port clk, input, 1 bit: single system clock; all state SHALL be on posedge clk.
REQ-004 Port n_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port key_mode, input, 1 bit: asynchronous pushbutton, active-low; a press advances the pattern mode.
REQ-006 Port key_speed, input, 1 bit: asynchronous pushbutton, active-low; a press advances the speed setting.
REQ-007 Port led, output, 4 bits: registered LED drive, active-low (0 = lit).
REQ-008 Port mode, output, 2 bits: registered current mode (0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK).

Function
REQ-009 Each key SHALL pass through a 2-flop synchronizer, then a debouncer that changes its accepted level only after DEB_MAX consecutive cycles of a new synchronized level.
REQ-010 Each debouncer SHALL emit a 1-cycle press pulse on an accepted 1->0 transition; a release SHALL emit no pulse.
REQ-011 Period SHALL be CNT_MAX << speed, with speed a 2-bit register; timer SHALL count 0..period-1 and wrap to 0; step SHALL be asserted when timer == period-1.
REQ-012 On step, led SHALL update per mode: ROT_L {led[2:0],led[3]}; ROT_R {led[0],led[3:1]}; BOUNCE moves the single 0 one place in dir; BLINK led <= ~led.
REQ-013 BOUNCE SHALL keep a dir flag (0 = toward MSB): at led==4'b0111 dir SHALL become 1 and, at led==4'b1110, 0, with the reversal and the move in the same step (sequence 1110,1101,1011,0111,1011,1101,1110,...).
REQ-014 A mode press SHALL set mode <= mode+1 (wrapping 3->0), clear the timer, and load led with the new mode's initial pattern: ROT_L 0111, ROT_R 0111, BOUNCE 1110 with dir=0, BLINK 0000.
REQ-015 A speed press SHALL set speed <= speed+1 (wrapping 3->0), clear the timer, and leave led and mode unchanged.
REQ-016 Mode and speed presses in the same cycle SHALL both take effect; the timer SHALL be cleared once.
REQ-017 A press coinciding with step SHALL take priority: the press actions apply and the step's led update is discarded.
REQ-018 The first step after any timer clear SHALL occur exactly period cycles later, using the new speed.
REQ-019 Latency from a key input edge to mode/led change SHALL be 2 synchronizer cycles + DEB_MAX + 1 cycles.

Reset
REQ-020 On n_reset low, asynchronously: mode=0, speed=0, timer=0, led=4'b0111, dir=0; synchronizers and accepted key levels = 1 (released); debounce counters = 0.
REQ-021 Reset asserted mid-step or mid-debounce SHALL discard partial state; no press pulse SHALL be emitted on reset release while keys are held high.

Structure
REQ-022 A shared package SHALL hold the mode encodings (ROT_L, ROT_R, BOUNCE, BLINK) and the initial LED patterns.
REQ-023 The debouncer SHALL be a sub-module, key_debounce (ports clk, n_reset, key_n, press), instantiated once per key.
REQ-024 Timer width SHALL be 32 bits; the shifted period SHALL be computed at 32 bits without overflow for legal CNT_MAX.

Verification (CNT_MAX=4, DEB_MAX=3)
REQ-025 Reset, no keys, 16 cycles -> led steps every 4 cycles 0111,1110,1101,1011,0111; mode=0.
REQ-026 key_mode low for 10 cycles -> after 6 cycles mode=1, led=0111, timer=0; next steps 1011,1101,1110.
REQ-027 key_mode glitch low for 2 cycles -> no mode change.
REQ-028 Three mode presses -> BOUNCE then BLINK; BOUNCE steps show 1110,1101,1011,0111,1011; BLINK shows 0000,1111,0000.
REQ-029 key_speed press twice -> period 16 cycles; a fourth press total returns the period to 4; led unchanged at each press.
REQ-030 Both keys pressed together, aligned with step -> mode+1, speed+1, led = initial pattern, next step 8 cycles later; n_reset pulse mid-run restores all REQ-020 values.

Source files
------------

// File: rtl/led_pattern_ctrl_pkg.sv
// Shared definitions for the LED pattern controller: mode encodings and
// the LED pattern each mode starts from (LEDs are active-low).
package led_pattern_ctrl_pkg;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_t;

    localparam logic [3:0] LED_INIT_ROT_L  = 4'b0111;
    localparam logic [3:0] LED_INIT_ROT_R  = 4'b0111;
    localparam logic [3:0] LED_INIT_BOUNCE = 4'b1110;
    localparam logic [3:0] LED_INIT_BLINK  = 4'b0000;

    // Bounce end points: the lit LED sits at the MSB or the LSB.
    localparam logic [3:0] BOUNCE_MSB_END  = 4'b0111;
    localparam logic [3:0] BOUNCE_LSB_END  = 4'b1110;

    function automatic logic [3:0] init_led(input mode_t m);
        logic [3:0] pattern;
        case (m)
            ROT_L:   pattern = LED_INIT_ROT_L;
            ROT_R:   pattern = LED_INIT_ROT_R;
            BOUNCE:  pattern = LED_INIT_BOUNCE;
            default: pattern = LED_INIT_BLINK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, level debouncer, and a
// one-cycle pulse when a press (accepted 1->0 transition) is recognised.
module key_debounce #(
    parameter logic [31:0] DEB_MAX = 32'd1_000_000
) (
    input  logic clk,
    input  logic n_reset,
    input  logic key_n,
    output logic press
);

    logic        sync1_reg;
    logic        sync2_reg;
    logic        level_reg;
    logic        press_reg;
    logic [31:0] cnt_reg;
    logic        accept;

    // The new level has now been seen for DEB_MAX consecutive cycles.
    assign accept = (sync2_reg != level_reg) && (cnt_reg == DEB_MAX - 32'd1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            press_reg <= accept && !sync2_reg;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg   <= '0;
                level_reg <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Four-LED pattern generator with mode and speed pushbuttons; the step
// period is CNT_MAX << speed clock cycles.
module led_pattern_ctrl
    import led_pattern_ctrl_pkg::*;
#(
    parameter logic [31:0] CNT_MAX = 32'd500_000,
    parameter logic [31:0] DEB_MAX = 32'd1_000_000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       key_mode,
    input  logic       key_speed,
    output logic [3:0] led,
    output logic [1:0] mode
);

    logic [1:0]  keys_n;
    logic [1:0]  press;

    assign keys_n = {key_speed, key_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEB_MAX (DEB_MAX)
            ) u_debounce (
                .clk     (clk),
                .n_reset (n_reset),
                .key_n   (keys_n[gi]),
                .press   (press[gi])
            );
        end
    endgenerate

    mode_t       mode_reg, mode_next;
    logic [1:0]  speed_reg, speed_next;
    logic [31:0] timer_reg, timer_next;
    logic [3:0]  led_reg, led_next;
    logic        dir_reg, dir_next;
    logic [32:0] period_wide;
    logic [31:0] period_last;
    logic        press_mode, press_speed, step, bounce_dir;

    assign press_mode  = press[0];
    assign press_speed = press[1];

    // 33-bit shift: CNT_MAX = 2^29 at speed 3 gives exactly 2^32.
    assign period_wide = {1'b0, CNT_MAX} << speed_reg;
    assign period_last = 32'(period_wide - 33'd1);
    assign step        = (timer_reg == period_last);

    // Direction reverses at either end in the same step as the move.
    assign bounce_dir = (led_reg == BOUNCE_MSB_END) ? 1'b1 :
                        (led_reg == BOUNCE_LSB_END) ? 1'b0 : dir_reg;

    always_comb begin
        mode_next  = mode_reg;
        speed_next = speed_reg;
        led_next   = led_reg;
        dir_next   = dir_reg;
        timer_next = timer_reg + 32'd1;
        if (press_mode || press_speed) begin
            timer_next = '0;
            if (press_mode) begin
                mode_next = mode_t'(mode_reg + 2'd1);
                led_next  = init_led(mode_next);
                dir_next  = 1'b0;
            end
            if (press_speed) begin
                speed_next = speed_reg + 2'd1;
            end
        end else if (step) begin
            timer_next = '0;
            case (mode_reg)
                ROT_L:   led_next = {led_reg[2:0], led_reg[3]};
                ROT_R:   led_next = {led_reg[0], led_reg[3:1]};
                BOUNCE: begin
                    dir_next = bounce_dir;
                    led_next = bounce_dir ? {1'b1, led_reg[3:1]} : {led_reg[2:0], 1'b1};
                end
                default: led_next = ~led_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mode_reg  <= ROT_L;
            speed_reg <= 2'd0;
            timer_reg <= '0;
            led_reg   <= LED_INIT_ROT_L;
            dir_reg   <= 1'b0;
        end else begin
            mode_reg  <= mode_next;
            speed_reg <= speed_next;
            timer_reg <= timer_next;
            led_reg   <= led_next;
            dir_reg   <= dir_next;
        end
    end

    assign led  = led_reg;
    assign mode = mode_reg;

endmodule
